// File: rtl/bench_seq_recover.sv
// bench_seq_recover: rebuilds the input vectors of the 6-bit XOR-accumulating
// benchmark block from its observed state stream and buffers them in a FIFO.
// Ports:
//   clk, reset (sync, active-high)
//   sync            reload baseline from obs_data, no vector produced
//   obs_valid/obs_data  observed state sample
//   rec_ready/rec_valid/rec_data  ready/valid output of recovered vectors
//   level           FIFO occupancy
//   overflow        sticky drop flag
//   rec_count       saturating count of pushed vectors
// Optional feature: BENCH_SEQ_RECOVER_ZERO_DROP_EN suppresses zero vectors.
module bench_seq_recover #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sync,
    input  logic                     obs_valid,
    input  logic [5:0]               obs_data,
    input  logic                     rec_ready,
    output logic                     rec_valid,
    output logic [5:0]               rec_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [CNT_W-1:0]         rec_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        RESYNC
    } state_t;

    state_t state;
    state_t state_nx;

    logic [5:0]    baseline;
    logic [5:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic       do_sample;
    logic       want;
    logic       pop;
    logic       full;
    logic       push;
    logic       drop;
    logic [5:0] vec;

    always_comb begin
        state_nx = state;
        if (sync) begin
            state_nx = RESYNC;
        end else begin
            unique case (state)
                IDLE:    if (obs_valid) state_nx = RUN;
                RESYNC:  state_nx = RUN;
                default: state_nx = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Datapath is identical in every state; baseline 0 after reset matches
    // the source block's reset state, so IDLE needs no special handling.
    assign do_sample = obs_valid && !sync;
    assign vec       = obs_data ^ baseline;

`ifdef BENCH_SEQ_RECOVER_ZERO_DROP_EN
    assign want = do_sample && (vec != 6'd0);
`else
    assign want = do_sample;
`endif

    assign rec_valid = (level != '0);
    assign full      = (level == FULL_LVL);
    assign pop       = rec_valid && rec_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push      = want && (!full || pop);
    assign drop      = want && full && !pop;
    assign rec_data  = rec_valid ? mem[rd_ptr] : 6'd0;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= vec;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            baseline  <= 6'd0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            rec_count <= '0;
        end else begin
            if (sync || obs_valid) baseline <= obs_data;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (drop) overflow <= 1'b1;
            if (push && rec_count != CNT_MAX) rec_count <= rec_count + 1'b1;
        end
    end

endmodule
